// File: rtl/frame_capture_pkg.sv
// Shared state type and default geometry for the frame capture controller.
package frame_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam int DEF_H_RES  = 640;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_ADDR_W = 19;

endpackage

// File: rtl/frame_capture_ctrl_fb_rd_addr.sv
// Display-side frame-buffer read address: row-major linear address, zero when
// the requested coordinate falls outside the active image.
module fb_rd_addr
    import frame_capture_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        rd_x,
    input  logic [9:0]        rd_y,
    output logic [ADDR_W-1:0] rd_addr
);

    localparam int AW1 = ADDR_W + 1;
    localparam logic [31:0]    H_LIM = 32'(H_RES);
    localparam logic [31:0]    V_LIM = 32'(V_RES);
    localparam logic [AW1-1:0] H_MUL = AW1'(H_RES);

    logic              in_range_s;
    logic [AW1-1:0]    lin_s;
    logic [ADDR_W-1:0] rd_addr_r;

    // Coordinate clamp and linear address, one bit wider than the buffer
    always_comb begin
        in_range_s = ({22'd0, rd_x} < H_LIM) && ({22'd0, rd_y} < V_LIM);
        lin_s      = AW1'(rd_y) * H_MUL + AW1'(rd_x);
    end

    // Registered read address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_r <= {ADDR_W{1'b0}};
        end else if (in_range_s && !lin_s[ADDR_W]) begin
            rd_addr_r <= lin_s[ADDR_W-1:0];
        end else begin
            rd_addr_r <= {ADDR_W{1'b0}};
        end
    end

    assign rd_addr = rd_addr_r;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Captures one CSI frame of RGB888 pixels into a linear frame buffer.
// Define FRAME_CAPTURE_CONTINUOUS_EN to re-arm automatically after every frame.
module frame_capture_ctrl
    import frame_capture_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              line_end,
    input  logic              pix_valid,
    input  logic [23:0]       pix_data,
    input  logic [9:0]        rd_x,
    input  logic [9:0]        rd_y,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [9:0]        line_count
);

    localparam int AW1 = ADDR_W + 1;
    localparam logic [AW1-1:0] PIX_TOTAL = AW1'(H_RES * V_RES);
    localparam logic [9:0]     LINE_MAX  = 10'(V_RES);

    cap_state_t        state_r;
    cap_state_t        next_s;
    logic [AW1-1:0]    addr_r;
    logic [9:0]        line_count_r;
    logic              overflow_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [23:0]       wr_data_r;
    logic              capture_s;
    logic              start_s;
    logic              full_s;

    // Next-state decode; a frame_start inside CAPTURE restarts rather than ends
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arm) next_s = ST_ARMED;
                else     next_s = ST_IDLE;
            end
            ST_ARMED: begin
                if (frame_start) next_s = ST_CAPTURE;
                else             next_s = ST_ARMED;
            end
            ST_CAPTURE: begin
                if (frame_end && !frame_start) next_s = ST_DONE;
                else                           next_s = ST_CAPTURE;
            end
            ST_DONE: begin
`ifdef FRAME_CAPTURE_CONTINUOUS_EN
                next_s = ST_ARMED;
`else
                if (arm) next_s = ST_ARMED;
                else     next_s = ST_DONE;
`endif
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // Capture qualifiers
    always_comb begin
        capture_s = (state_r == ST_CAPTURE);
        start_s   = frame_start && ((state_r == ST_ARMED) || capture_s);
        full_s    = (addr_r == PIX_TOTAL);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= next_s;
    end

    // Write datapath: pixels past the buffer end are dropped and flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r       <= {AW1{1'b0}};
            line_count_r <= 10'd0;
            overflow_r   <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= {ADDR_W{1'b0}};
            wr_data_r    <= 24'd0;
        end else begin
            wr_en_r <= 1'b0;
            if (start_s) begin
                addr_r       <= {AW1{1'b0}};
                line_count_r <= 10'd0;
                if (!capture_s) overflow_r <= 1'b0;
            end else if (capture_s) begin
                if (pix_valid) begin
                    if (full_s) begin
                        overflow_r <= 1'b1;
                    end else begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= addr_r[ADDR_W-1:0];
                        wr_data_r <= pix_data;
                        addr_r    <= addr_r + {{ADDR_W{1'b0}}, 1'b1};
                    end
                end
                if (line_end && (line_count_r < LINE_MAX)) begin
                    line_count_r <= line_count_r + 10'd1;
                end
            end
        end
    end

    fb_rd_addr #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .ADDR_W(ADDR_W)
    ) u_rd_addr (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_x   (rd_x),
        .rd_y   (rd_y),
        .rd_addr(rd_addr)
    );

    assign busy       = (state_r == ST_ARMED) || (state_r == ST_CAPTURE);
    assign done       = (state_r == ST_DONE);
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign overflow   = overflow_r;
    assign line_count = line_count_r;

endmodule
